pe_column_stream: RTL and testbench

Parametrised successor to the fixed 10-lane PE column. NUM_PE signed MAC cells are chained vertically: clear and B operand ripple down one PE per cycle, and each PE takes its A operand from one lane of the incoming A word. Lane results are captured with a diagonal write-enable skew and assembled into an output word. The finished word is presented on a valid/ready handshake to the output global buffer writer. Bad write-enable spacing and output back-pressure are detected and flagged, not silently corrupted.

---
 rtl/pe_column_pkg.sv | 29 ++
 rtl/pe_mac.sv | 58 +++++
 rtl/pe_column_stream.sv | 132 +++++++++++++
 tb/tb_pe_column_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_column_pkg.sv
// rtl/pe_column_pkg.sv - shared constants and helpers for the PE column
package pe_column_pkg;

  localparam int DEF_NUM_PE     = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_OUTPUT_LAT = 1;

  // Working width for the generic saturate helper (accumulators up to 64 bits)
  localparam int SAT_W = 64;

  // Lowest bit of lane 'lane' inside a packed word of 'width'-bit lanes
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((64'd1 << (width - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - one signed MAC cell with registered clr/srcb/srca pass-through
module pe_mac
  import pe_column_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  clr_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic                           clr_q;
  logic [DATA_WIDTH-1:0]          a_q;
  logic [DATA_WIDTH-1:0]          b_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign a_ext = (2*DATA_WIDTH)'($signed(a_i));
  assign b_ext = (2*DATA_WIDTH)'($signed(b_i));
  assign prod  = a_ext * b_ext;

  // Accumulator restarts on clr, otherwise adds the sign-extended product (wraps)
  always_comb begin
    acc_d = acc_q + ACC_WIDTH'(prod);
    if (clr_i) acc_d = ACC_WIDTH'(prod);
  end

  // Pass-through registers and accumulator state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      clr_q <= clr_i;
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign clr_o = clr_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/pe_column_stream.sv
// rtl/pe_column_stream.sv - PE column with skewed lane capture and valid/ready output (PE_COLUMN_SAT_EN selects saturating lanes)
module pe_column_stream
  import pe_column_pkg::*;
#(
  parameter int NUM_PE     = DEF_NUM_PE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUTPUT_LAT = DEF_OUTPUT_LAT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  output logic                         clr_o,
  input  logic                         we_i,
  output logic                         we_o,
  input  logic [NUM_PE*DATA_WIDTH-1:0] srca_word_i,
  output logic [NUM_PE*DATA_WIDTH-1:0] srca_word_o,
  input  logic [DATA_WIDTH-1:0]        srcb_i,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic [NUM_PE*DATA_WIDTH-1:0] wordp_o,
  output logic                         ovf_o
);

  localparam int WORD_W = NUM_PE * DATA_WIDTH;
  localparam int SR_TOP = OUTPUT_LAT + NUM_PE - 1;
  localparam int CNT_W  = $clog2(NUM_PE);

  logic                  clr_chain [NUM_PE+1];
  logic [DATA_WIDTH-1:0] b_chain   [NUM_PE+1];
  logic [ACC_WIDTH-1:0]  psum      [NUM_PE];
  logic [DATA_WIDTH-1:0] lane_res  [NUM_PE];

  assign clr_chain[0] = clr_i;
  assign b_chain[0]   = srcb_i;

  genvar k;
  generate
    for (k = 0; k < NUM_PE; k++) begin : g_pe
      pe_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(clr_chain[k]),
        .a_i  (srca_word_i[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
        .b_i  (b_chain[k]),
        .clr_o(clr_chain[k+1]),
        .a_o  (srca_word_o[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
        .b_o  (b_chain[k+1]),
        .acc_o(psum[k])
      );
`ifdef PE_COLUMN_SAT_EN
      assign lane_res[k] = DATA_WIDTH'(saturate(SAT_W'($signed(psum[k])), DATA_WIDTH));
`else
      assign lane_res[k] = psum[k][DATA_WIDTH-1:0];
`endif
    end
  endgenerate

  assign clr_o = clr_chain[1];

  logic              we_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_TOP:1]   shift_q, shift_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              we_acc, we_bad, last_cap, can_load;

  assign we_acc   = we_i && (cnt_q == '0);
  assign we_bad   = we_i && (cnt_q != '0);
  assign last_cap = shift_q[SR_TOP];
  assign can_load = !valid_q || word_ready_i;

  // Spacing guard, capture skew, lane assembly and output hand-off
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = {shift_q[SR_TOP-1:1], we_acc};
    asm_d   = asm_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | we_bad;

    if (we_acc)              cnt_d = CNT_W'(NUM_PE - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;

    for (int i = 0; i < NUM_PE; i++) begin
      if (shift_q[OUTPUT_LAT+i]) asm_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_res[i];
    end

    if (valid_q && word_ready_i) valid_d = 1'b0;

    if (last_cap) begin
      if (can_load) begin
        out_d   = asm_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any word in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q    <= we_i;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign we_o         = we_q;
  assign word_valid_o = valid_q;
  assign wordp_o      = out_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_pe_column_stream.sv
// tb/tb_pe_column_stream.sv - directed self-checking bench for pe_column_stream
module tb_pe_column_stream;

  localparam int W = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clr_i;
  logic          clr_o;
  logic          we_i;
  logic          we_o;
  logic [W-1:0]  srca_word_i;
  logic [W-1:0]  srca_word_o;
  logic [15:0]   srcb_i;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [W-1:0]  wordp_o;
  logic          ovf_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] w_a3  = {8{16'h0003}};
  logic [W-1:0] w_12  = {8{16'h0012}};
  logic [W-1:0] w_03  = {8{16'h0003}};
  logic [W-1:0] w_7f  = {8{16'h7FFF}};
`ifdef PE_COLUMN_SAT_EN
  logic [W-1:0] w_sat = {8{16'h7FFF}};
`else
  logic [W-1:0] w_sat = {8{16'h0001}};
`endif

  pe_column_stream dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .clr_o       (clr_o),
    .we_i        (we_i),
    .we_o        (we_o),
    .srca_word_i (srca_word_i),
    .srca_word_o (srca_word_o),
    .srcb_i      (srcb_i),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .wordp_o     (wordp_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  // Reset, then leave the bench 1 time unit into cycle 0 with clean state
  task automatic begin_test();
    rst_i = 1'b1;
    clr_i = 1'b0; we_i = 1'b0; srcb_i = '0; srca_word_i = '0; word_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Word 1: clr at 0, srcb=2 for 0..2, we at 2. Optional word 2: clr+srcb=1 at 8, we at 10.
  task automatic drive(input int c, input bit second, input bit early);
    clr_i  = (c == 0) || (second && c == 8);
    srcb_i = (c <= 2) ? 16'd2 : ((second && c == 8) ? 16'd1 : 16'd0);
    we_i   = (c == 2) || (second && c == 10) || (early && c == 5);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clr_i = 1'b1; we_i = 1'b1; srcb_i = 16'h1234; srca_word_i = w_7f; word_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (clr_o !== 1'b0) begin errors++; $display("FAIL reset_clr_o got %0b exp 0", clr_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL reset_we_o got %0b exp 0", we_o); end
    checks++; if (srca_word_o !== '0) begin errors++; $display("FAIL reset_srca_word_o got %h exp 0", srca_word_o); end
    checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", word_valid_o); end
    checks++; if (wordp_o !== '0) begin errors++; $display("FAIL reset_wordp got %h exp 0", wordp_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf_o); end
  endtask

  task automatic test_basic();
    begin_test();
    srca_word_i = w_a3; word_ready_i = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      drive(c, 1'b0, 1'b0);
      if (c == 1) begin
        checks++; if (clr_o !== 1'b1) begin errors++; $display("FAIL basic_clr_o_lat got %0b exp 1", clr_o); end
        checks++; if (srca_word_o !== w_a3) begin errors++; $display("FAIL basic_srca_lat got %h exp %h", srca_word_o, w_a3); end
      end
      if (c == 3) begin
        checks++; if (we_o !== 1'b1) begin errors++; $display("FAIL basic_we_o_lat got %0b exp 1", we_o); end
      end
      checks++;
      if (word_valid_o !== (c == 11)) begin
        errors++; $display("FAIL basic_valid c=%0d got %0b exp %0b", c, word_valid_o, (c == 11));
      end
      if (c == 11) begin
        checks++; if (wordp_o !== w_12) begin errors++; $display("FAIL basic_word got %h exp %h", wordp_o, w_12); end
      end
      next();
    end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b exp 0", ovf_o); end
  endtask

  task automatic test_backpressure();
    begin_test();
    srca_word_i = w_a3;
    for (int c = 0; c <= 17; c++) begin
      drive(c, 1'b0, 1'b0);
      word_ready_i = (c >= 15);
      if (c >= 11 && c <= 15) begin
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got %0b exp 1", c, word_valid_o); end
        checks++; if (wordp_o !== w_12) begin errors++; $display("FAIL bp_word c=%0d got %h exp %h", c, wordp_o, w_12); end
      end
      if (c == 10 || c == 16) begin
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid c=%0d got %0b exp 0", c, word_valid_o); end
      end
      next();
    end
  endtask

  task automatic test_early_we();
    begin_test();
    srca_word_i = w_a3; word_ready_i = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      drive(c, 1'b0, 1'b1);
      if (c == 5) begin
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL early_ovf_pre got %0b exp 0", ovf_o); end
      end
      if (c == 6) begin
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL early_ovf_rise got %0b exp 1", ovf_o); end
      end
      if (c >= 3) begin
        checks++;
        if (word_valid_o !== (c == 11)) begin
          errors++; $display("FAIL early_valid c=%0d got %0b exp %0b", c, word_valid_o, (c == 11));
        end
      end
      if (c == 11) begin
        checks++; if (wordp_o !== w_12) begin errors++; $display("FAIL early_word got %h exp %h", wordp_o, w_12); end
      end
      next();
    end
  endtask

  task automatic test_back_to_back();
    begin_test();
    srca_word_i = w_a3; word_ready_i = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      drive(c, 1'b1, 1'b0);
      checks++;
      if (word_valid_o !== (c == 11 || c == 19)) begin
        errors++; $display("FAIL b2b_valid c=%0d got %0b exp %0b", c, word_valid_o, (c == 11 || c == 19));
      end
      if (c == 11) begin
        checks++; if (wordp_o !== w_12) begin errors++; $display("FAIL b2b_word1 got %h exp %h", wordp_o, w_12); end
      end
      if (c == 19) begin
        checks++; if (wordp_o !== w_03) begin errors++; $display("FAIL b2b_word2 got %h exp %h", wordp_o, w_03); end
      end
      next();
    end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b exp 0", ovf_o); end
  endtask

  task automatic test_out_overflow();
    begin_test();
    srca_word_i = w_a3;
    for (int c = 0; c <= 22; c++) begin
      drive(c, 1'b1, 1'b0);
      word_ready_i = (c >= 20);
      if (c == 18) begin
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL oo_ovf_pre got %0b exp 0", ovf_o); end
      end
      if (c == 19) begin
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL oo_ovf got %0b exp 1", ovf_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL oo_valid got %0b exp 1", word_valid_o); end
        checks++; if (wordp_o !== w_12) begin errors++; $display("FAIL oo_word_held got %h exp %h", wordp_o, w_12); end
      end
      if (c == 21 || c == 22) begin
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL oo_no_second c=%0d got %0b exp 0", c, word_valid_o); end
      end
      next();
    end
  endtask

  task automatic test_saturation();
    begin_test();
    srca_word_i = w_7f; word_ready_i = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      clr_i  = (c == 0);
      srcb_i = (c == 0) ? 16'h7FFF : 16'h0000;
      we_i   = (c == 0);
      checks++;
      if (word_valid_o !== (c == 9)) begin
        errors++; $display("FAIL sat_valid c=%0d got %0b exp %0b", c, word_valid_o, (c == 9));
      end
      if (c == 9) begin
        checks++; if (wordp_o !== w_sat) begin errors++; $display("FAIL sat_word got %h exp %h", wordp_o, w_sat); end
      end
      next();
    end
  endtask

  task automatic test_reset_mid();
    bit seen_valid;
    seen_valid = 1'b0;
    begin_test();
    srca_word_i = w_a3; word_ready_i = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      drive(c, 1'b0, 1'b0);
      if (c == 6) begin
        rst_i = 1'b1;
        #1;
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b exp 0", word_valid_o); end
        checks++; if (wordp_o !== '0) begin errors++; $display("FAIL rmid_wordp got %h exp 0", wordp_o); end
        checks++; if (srca_word_o !== '0) begin errors++; $display("FAIL rmid_srca got %h exp 0", srca_word_o); end
        checks++; if ({clr_o, we_o, ovf_o} !== 3'b000) begin errors++; $display("FAIL rmid_ctl got %b exp 000", {clr_o, we_o, ovf_o}); end
      end
      if (c == 7) rst_i = 1'b0;
      if (word_valid_o) seen_valid = 1'b1;
      next();
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_word got %0b exp 0", seen_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_we();
    test_back_to_back();
    test_out_overflow();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
